muldiv_hilo: RTL

- Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the EX-stage ALU.
- Serves MULT/MULTU/DIV/DIVU in place of the single-cycle ALU paths, and holds HI/LO for MFHI/MFLO/MTHI/MTLO.
- Iterates one bit per clock. The hazard unit stalls the pipeline on `busy`.

---
 rtl/muldiv_hilo_if.sv | 29 ++
 rtl/muldiv_hilo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The pipeline side is the master; the unit itself is the slave.
interface muldiv_hilo_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per
// clock on magnitudes; a final cycle applies signs and writes HI/LO.
module muldiv_hilo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_hilo_if.slave   mdu
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam int unsigned       W2       = 2 * WIDTH;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [W2-1:0]     acc_q,   acc_d;
    logic [WIDTH-1:0]  a_mag_q, a_mag_d;
    logic [WIDTH-1:0]  b_mag_q, b_mag_d;
    logic [1:0]        op_q,    op_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              bzero_q, bzero_d;
    logic [WIDTH-1:0]  hi_q,    hi_d;
    logic [WIDTH-1:0]  lo_q,    lo_d;
    logic              done_q,  done_d;
    logic              dbz_q,   dbz_d;

    // Operand conditioning at launch: negative operands of signed ops become
    // magnitudes; the sign flags are zero for unsigned ops, so the FIX cycle
    // never needs to look at op[0] again.
    logic              a_neg_in, b_neg_in;
    logic [WIDTH-1:0]  a_mag_in, b_mag_in;

    always_comb begin
        a_neg_in = ~mdu.op[0] & mdu.a[WIDTH-1];
        b_neg_in = ~mdu.op[0] & mdu.b[WIDTH-1];
        a_mag_in = a_neg_in ? -mdu.a : mdu.a;
        b_mag_in = b_neg_in ? -mdu.b : mdu.b;
    end

    // One iteration step for each algorithm, computed from the accumulator.
    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    logic [WIDTH:0]  mul_sum;
    logic [W2-1:0]   mul_next;
    logic [WIDTH:0]  div_trial;
    logic [W2-1:0]   div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, a_mag_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[W2-1:WIDTH], acc_q[WIDTH-1:1]};
        div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_mag_q};
        div_next  = div_trial[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // Sign fix-up of the finished magnitudes, and the forced divide-by-zero result.
    logic [W2-1:0]     prod_fix;
    logic [WIDTH-1:0]  quo_fix, rem_fix, a_orig;

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_a_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
        a_orig   = neg_a_q ? -a_mag_q : a_mag_q;
    end

    // Next-state and register-update logic for the IDLE/CALC/FIX sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mdu.mthi) hi_d = mdu.wdata;
                if (mdu.mtlo) lo_d = mdu.wdata;
                if (mdu.start && !mdu.cancel) begin
                    a_mag_d = a_mag_in;
                    b_mag_d = b_mag_in;
                    neg_a_d = a_neg_in;
                    neg_b_d = b_neg_in;
                    op_d    = mdu.op;
                    bzero_d = (mdu.b == '0);
                    cnt_d   = '0;
                    acc_d   = mdu.op[1] ? {{WIDTH{1'b0}}, a_mag_in}
                                        : {{WIDTH{1'b0}}, b_mag_in};
                    state_d = ST_CALC;
                end
            end

            ST_CALC: begin
                if (mdu.cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = op_q[1] ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                if (!mdu.cancel) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod_fix[W2-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else begin
                        dbz_d = bzero_q;
                        if (bzero_q) begin
                            hi_d = a_orig;
                            lo_d = '1;
                        end else begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            bzero_q <= bzero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign mdu.busy        = (state_q != ST_IDLE);
    assign mdu.done        = done_q;
    assign mdu.div_by_zero = dbz_q;
    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;

endmodule
